fir_mc_serial: RTL

//  Multi-channel, time-multiplexed serial-MAC FIR filter; successor to the single-channel FIR_filter.

---
 rtl/fir_mc_serial_if.sv | 35 +++
 rtl/fir_mc_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fir_mc_serial_if.sv
// Sample, coefficient and result channels of the multi-channel serial FIR.
// The master side drives samples/coefficients and consumes results.
interface fir_mc_serial_if #(
    parameter int unsigned LENGTH   = 64,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2
);
    localparam int unsigned CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW      = $clog2(LENGTH);
    localparam int unsigned WIDTH_O = 2 * WIDTH + AW;

    logic                      valid_Input;
    logic                      ready_Input;
    logic [CH_BITS-1:0]        ch_Input;
    logic signed [WIDTH-1:0]   FIR_input;

    logic                      coef_we;
    logic [AW-1:0]             coef_addr;
    logic signed [WIDTH-1:0]   coef_data;

    logic                      Output_valid;
    logic                      Output_ready;
    logic [CH_BITS-1:0]        Output_ch;
    logic signed [WIDTH_O-1:0] FIR_output;

    modport master (
        output valid_Input, ch_Input, FIR_input, coef_we, coef_addr, coef_data, Output_ready,
        input  ready_Input, Output_valid, Output_ch, FIR_output
    );

    modport slave (
        input  valid_Input, ch_Input, FIR_input, coef_we, coef_addr, coef_data, Output_ready,
        output ready_Input, Output_valid, Output_ch, FIR_output
    );
endinterface

// File: rtl/fir_mc_serial.sv
// Multi-channel time-multiplexed FIR: one shared signed multiplier, one tap per clock,
// per-channel circular sample histories and a runtime-writable coefficient bank.
module fir_mc_serial #(
    parameter int unsigned LENGTH   = 64,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 2
) (
    input logic            clk,
    input logic            rst,
    fir_mc_serial_if.slave bus
);
    localparam int unsigned CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned AW      = $clog2(LENGTH);
    localparam int unsigned PW      = 2 * WIDTH;
    localparam int unsigned WIDTH_O = PW + AW;
    localparam logic [AW:0] CntEnd  = (AW + 1)'(LENGTH);

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CH_BITS-1:0]        ch_q, ch_d;
    logic [AW:0]               cnt_q, cnt_d;
    logic signed [PW-1:0]      prod_q, prod_d;
    logic signed [WIDTH_O-1:0] acc_q, acc_d;
    logic signed [WIDTH_O-1:0] out_q, out_d;
    logic [CH_BITS-1:0]        out_ch_q, out_ch_d;
    logic [AW-1:0]             wptr_q [CHANNELS];
    logic [AW-1:0]             wptr_d [CHANNELS];
    logic signed [WIDTH-1:0]   hist_q [CHANNELS][LENGTH];
    logic signed [WIDTH-1:0]   hist_d [CHANNELS][LENGTH];
    logic signed [WIDTH-1:0]   coef_q [LENGTH];
    logic signed [WIDTH-1:0]   coef_d [LENGTH];

    logic                      ready;
    logic                      accept;
    logic                      ch_ok;
    logic [AW-1:0]             tap;
    logic [AW-1:0]             rd_idx;
    logic signed [WIDTH-1:0]   x_rd;
    logic signed [WIDTH-1:0]   c_rd;
    logic signed [WIDTH_O-1:0] prod_ext;
    logic signed [WIDTH_O-1:0] acc_sum;

    // ready is gated by rst so it reads low for the whole reset pulse
    assign ready  = (state_q == StIdle) && !rst;
    assign accept = bus.valid_Input && ready;
    assign ch_ok  = 32'(bus.ch_Input) < CHANNELS;

    // Write pointer already points past the newest sample, hence the extra -1
    assign tap      = cnt_q[AW-1:0];
    assign rd_idx   = wptr_q[ch_q] - AW'(1) - tap;
    assign x_rd     = hist_q[ch_q][rd_idx];
    assign c_rd     = coef_q[tap];
    assign prod_ext = {{(WIDTH_O - PW){prod_q[PW-1]}}, prod_q};
    assign acc_sum  = acc_q + prod_ext;

    assign bus.ready_Input  = ready;
    assign bus.Output_valid = (state_q == StDone);
    assign bus.Output_ch    = out_ch_q;
    assign bus.FIR_output   = out_q;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        acc_d    = acc_q;
        out_d    = out_q;
        out_ch_d = out_ch_q;
        wptr_d   = wptr_q;
        hist_d   = hist_q;
        coef_d   = coef_q;

        unique case (state_q)
            StIdle: begin
                // Coefficient write lands in the same edge as a sample accept, ahead of tap 0
                if (bus.coef_we) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (accept && ch_ok) begin
                    hist_d[bus.ch_Input][wptr_q[bus.ch_Input]] = bus.FIR_input;
                    wptr_d[bus.ch_Input] = wptr_q[bus.ch_Input] + AW'(1);
                    ch_d    = bus.ch_Input;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                // Multiplier is registered: tap k is formed at count k, summed at count k+1
                if (cnt_q != '0) begin
                    acc_d = acc_sum;
                end
                if (cnt_q == CntEnd) begin
                    out_d    = acc_sum;
                    out_ch_d = ch_q;
                    state_d  = StDone;
                end else begin
                    prod_d = PW'(x_rd) * PW'(c_rd);
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.Output_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            out_ch_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                for (int k = 0; k < LENGTH; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < LENGTH; k++) begin
                coef_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            out_ch_q <= out_ch_d;
            wptr_q   <= wptr_d;
            hist_q   <= hist_d;
            coef_q   <= coef_d;
        end
    end
endmodule
